cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter ROB_WIDTH_BIT, default 4, width of a RoB entry index.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, holding-FIFO entries per requester (power of two, >=2).
REQ-003 SHALL have port clk_in  input  1  system clock; one clock, all state on posedge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rdy_in  input  1  global ready; low pauses the block.
REQ-006 SHALL have port clear  input  1  RoB flush (mispredict), synchronous.
REQ-007 SHALL have port req_valid  input  3  per-requester result valid (0=ALU/RS, 1=LSB, 2=branch unit).
REQ-008 SHALL have port req_rob_id  input  3*ROB_WIDTH_BIT  per-requester RoB id, requester i at bits [i*W +: W].
REQ-009 SHALL have port req_value  input  96  per-requester 32-bit result, requester i at bits [i*32 +: 32].
REQ-010 SHALL have port req_ready  output  3  per-requester accept, combinational.
REQ-011 SHALL have port cdb_valid  output  1  broadcast valid, registered.
REQ-012 SHALL have port cdb_rob_id  output  ROB_WIDTH_BIT  broadcast RoB id, registered.
REQ-013 SHALL have port cdb_value  output  32  broadcast result, registered.
REQ-014 SHALL have port cdb_src  output  2  granted requester index, registered.

Function
REQ-015 SHALL keep one FIFO of FIFO_DEPTH {rob_id,value} entries per requester, with head/tail pointers wrapping modulo FIFO_DEPTH and a count 0..FIFO_DEPTH.
REQ-016 SHALL drive req_ready[i] = rdy_in && !clear && count[i] < FIFO_DEPTH; a full FIFO is not ready even if it pops this cycle (no pop-through).
REQ-017 SHALL push requester i on a posedge where req_valid[i] && req_ready[i]; all three may push on the same edge.
REQ-018 SHALL arbitrate each posedge with rdy_in high and clear low among non-empty FIFOs using state before the edge, priority order rr, rr+1, rr+2 (mod 3).
REQ-019 SHALL, on a grant to i: pop FIFO i, load cdb_rob_id/cdb_value from its head, cdb_src<=i, cdb_valid<=1, rr<=(i+1) mod 3.
REQ-020 SHALL, with no non-empty FIFO: cdb_valid<=0, cdb_rob_id/cdb_value/cdb_src and rr hold.
REQ-021 SHALL give latency: entry pushed at edge E broadcasts no earlier than edge E+1 (no same-edge bypass); cdb_valid lasts exactly one cycle per grant.
REQ-022 SHALL allow push and pop of the same FIFO on one edge, count unchanged.
REQ-023 SHALL grant at most one entry per edge and preserve per-requester FIFO order.
REQ-024 SHALL grant any non-empty FIFO within 3 consecutive arbitration edges (starvation-free).
REQ-025 SHALL, with rdy_in low and clear low, hold all state including cdb_valid; req_ready is 0.
REQ-026 SHALL, on a posedge with clear high (any rdy_in): empty all FIFOs, cdb_valid<=0, ignore req_valid; rr holds.
REQ-027 SHALL treat FIFO push with count==FIFO_DEPTH as unreachable; simulation errors and finishes if it occurs.

Reset
REQ-028 SHALL, on rst_in high, immediately and asynchronously clear: all counts/pointers 0, rr=0, cdb_valid=0, cdb_rob_id=0, cdb_value=0, cdb_src=0.
REQ-029 SHALL, with rst_in high, drive req_ready=0 and accept nothing; reset mid-operation discards all buffered entries.
REQ-030 SHALL resume on the first posedge after rst_in deasserts.

Verification
REQ-031 SHALL cover: after reset, ALU pushes id 3 value 0x11 at edge 1 -> cdb_valid=1, id 3, 0x11, src 0 after edge 2; cdb_valid=0 after edge 3.
REQ-032 SHALL cover: all three push at edge 1 (ids 1,2,3), rr=0 -> broadcasts src 0,1,2 after edges 2,3,4 in that order.
REQ-033 SHALL cover: LSB holds req_valid with ids 5,6,7 and no pop (rdy_in low) -> ids 5,6 accepted, req_ready[1]=0 while full, 7 accepted after first pop.
REQ-034 SHALL cover: 2 entries buffered, clear high one edge -> cdb_valid=0, counts 0, nothing broadcast afterwards.
REQ-035 SHALL cover: rdy_in low 5 cycles with cdb_valid=1, id 9 -> outputs hold id 9 unchanged, no pop until rdy_in high.
REQ-036 SHALL cover: rst_in asserted between edges with entries buffered -> outputs 0 before next edge; later push broadcasts normally.

Source files
------------

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Common-data-bus arbiter for three result producers (0 = ALU/RS, 1 = LSB,
//   2 = branch unit). Each producer writes {rob_id, value} into its own small
//   holding FIFO. On every active cycle one non-empty FIFO is chosen in
//   round-robin order and its head entry is broadcast on the registered CDB
//   outputs for exactly one cycle.
//
// Ports:
//   clk_in      in   system clock, all state on the rising edge
//   rst_in      in   asynchronous active-high reset
//   rdy_in      in   global ready; low freezes the whole block
//   clear       in   synchronous flush (mispredict): empties every FIFO
//   req_valid   in   [2:0]  per-producer result valid
//   req_rob_id  in   [3*W-1:0] per-producer RoB id, producer i at [i*W +: W]
//   req_value   in   [95:0] per-producer result, producer i at [i*32 +: 32]
//   req_ready   out  [2:0]  per-producer accept (combinational)
//   cdb_valid   out  broadcast valid (registered)
//   cdb_rob_id  out  broadcast RoB id (registered)
//   cdb_value   out  broadcast result (registered)
//   cdb_src     out  index of the producer that won the bus (registered)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int ROB_WIDTH_BIT = 4,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         clear,
    input  logic [2:0]                   req_valid,
    input  logic [3*ROB_WIDTH_BIT-1:0]   req_rob_id,
    input  logic [95:0]                  req_value,
    output logic [2:0]                   req_ready,
    output logic                         cdb_valid,
    output logic [ROB_WIDTH_BIT-1:0]     cdb_rob_id,
    output logic [31:0]                  cdb_value,
    output logic [1:0]                   cdb_src
);

    localparam int W  = ROB_WIDTH_BIT;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Arbitration (and therefore popping) only happens on cycles where the
    // block is running and not being flushed.
    logic arb_en;
    assign arb_en = rdy_in & ~clear;

    logic [2:0]   push;
    logic [2:0]   pop;
    logic [2:0]   nonempty;
    logic [3*W-1:0] head_rob_id;
    logic [95:0]  head_value;

    // -------------------------------------------------------------------------
    // Per-producer holding FIFOs
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
            logic [PW-1:0] head_q;
            logic [PW-1:0] head_d;
            logic [PW-1:0] tail_q;
            logic [PW-1:0] tail_d;
            logic [CW-1:0] count_q;
            logic [CW-1:0] count_d;

            logic [W-1:0]  rob_mem [FIFO_DEPTH];
            logic [31:0]   val_mem [FIFO_DEPTH];

            // Readiness looks only at the count before the edge: a full FIFO
            // stays not-ready even on a cycle where it is about to pop.
            assign req_ready[gi] = ~rst_in & rdy_in & ~clear & (count_q < DEPTH_C);
            assign push[gi]      = req_valid[gi] & req_ready[gi];
            assign nonempty[gi]  = (count_q != '0);

            assign head_rob_id[gi*W +: W]   = rob_mem[head_q];
            assign head_value[gi*32 +: 32]  = val_mem[head_q];

            always_comb begin
                head_d  = head_q;
                tail_d  = tail_q;
                count_d = count_q;
                if (clear) begin
                    head_d  = '0;
                    tail_d  = '0;
                    count_d = '0;
                end else begin
                    // Depth is a power of two, so plain overflow wraps the
                    // pointers modulo FIFO_DEPTH.
                    if (push[gi]) begin
                        tail_d = tail_q + PW'(1);
                    end
                    if (pop[gi]) begin
                        head_d = head_q + PW'(1);
                    end
                    case ({push[gi], pop[gi]})
                        2'b10:   count_d = count_q + CW'(1);
                        2'b01:   count_d = count_q - CW'(1);
                        default: count_d = count_q;
                    endcase
                end
            end

            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    head_q  <= '0;
                    tail_q  <= '0;
                    count_q <= '0;
                end else begin
                    head_q  <= head_d;
                    tail_q  <= tail_d;
                    count_q <= count_d;
                end
            end

            // Storage carries no reset: only entries covered by count_q are
            // ever read, so stale contents are harmless.
            always_ff @(posedge clk_in) begin
                if (push[gi]) begin
                    assert (count_q != DEPTH_C)
                        else $fatal(1, "cdb_arbiter: push into full FIFO %0d", gi);
                    rob_mem[tail_q] <= req_rob_id[gi*W +: W];
                    val_mem[tail_q] <= req_value[gi*32 +: 32];
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin arbitration
    // -------------------------------------------------------------------------
    logic [1:0] rr_q;
    logic [1:0] rr_d;
    logic [1:0] cand0;
    logic [1:0] cand1;
    logic [1:0] cand2;
    logic       grant_vld;
    logic [1:0] grant_idx;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    always_comb begin
        // rr_q only ever holds 0..2; the guard keeps the index in range anyway.
        cand0     = (rr_q > 2'd2) ? 2'd0 : rr_q;
        cand1     = next_idx(cand0);
        cand2     = next_idx(cand1);
        grant_vld = arb_en & (|nonempty);
        if (nonempty[cand0]) begin
            grant_idx = cand0;
        end else if (nonempty[cand1]) begin
            grant_idx = cand1;
        end else begin
            grant_idx = cand2;
        end
        pop = grant_vld ? (3'b001 << grant_idx) : 3'b000;
    end

    // -------------------------------------------------------------------------
    // Registered CDB outputs
    // -------------------------------------------------------------------------
    logic         cdb_valid_q;
    logic         cdb_valid_d;
    logic [W-1:0] cdb_rob_id_q;
    logic [W-1:0] cdb_rob_id_d;
    logic [31:0]  cdb_value_q;
    logic [31:0]  cdb_value_d;
    logic [1:0]   cdb_src_q;
    logic [1:0]   cdb_src_d;

    always_comb begin
        cdb_valid_d  = cdb_valid_q;
        cdb_rob_id_d = cdb_rob_id_q;
        cdb_value_d  = cdb_value_q;
        cdb_src_d    = cdb_src_q;
        rr_d         = rr_q;
        if (clear) begin
            // Flush kills any broadcast in flight; payload and rr are kept.
            cdb_valid_d = 1'b0;
        end else if (rdy_in) begin
            if (grant_vld) begin
                cdb_valid_d  = 1'b1;
                cdb_rob_id_d = head_rob_id[grant_idx*W +: W];
                cdb_value_d  = head_value[grant_idx*32 +: 32];
                cdb_src_d    = grant_idx;
                rr_d         = next_idx(grant_idx);
            end else begin
                cdb_valid_d = 1'b0;
            end
        end
        // rdy_in low without clear: everything holds, including cdb_valid.
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cdb_valid_q  <= 1'b0;
            cdb_rob_id_q <= '0;
            cdb_value_q  <= '0;
            cdb_src_q    <= '0;
            rr_q         <= '0;
        end else begin
            cdb_valid_q  <= cdb_valid_d;
            cdb_rob_id_q <= cdb_rob_id_d;
            cdb_value_q  <= cdb_value_d;
            cdb_src_q    <= cdb_src_d;
            rr_q         <= rr_d;
        end
    end

    assign cdb_valid  = cdb_valid_q;
    assign cdb_rob_id = cdb_rob_id_q;
    assign cdb_value  = cdb_value_q;
    assign cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Self-checking bench for cdb_arbiter: a table of per-cycle vectors for the
// basic single/triple push cases, hand-written sequences for back-pressure,
// stall, flush and mid-run reset, and a scoreboard queue that receives the
// expected broadcast whenever stimulus is driven and is popped on every fresh
// CDB broadcast.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int W = 4;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b0;
    logic             rdy_in;
    logic             clear;
    logic [2:0]       req_valid;
    logic [3*W-1:0]   req_rob_id;
    logic [95:0]      req_value;
    logic [2:0]       req_ready;
    logic             cdb_valid;
    logic [W-1:0]     cdb_rob_id;
    logic [31:0]      cdb_value;
    logic [1:0]       cdb_src;

    cdb_arbiter #(.ROB_WIDTH_BIT(W), .FIFO_DEPTH(2)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_rob_id (req_rob_id),
        .req_value  (req_value),
        .req_ready  (req_ready),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_value  (cdb_value),
        .cdb_src    (cdb_src)
    );

    always #5 clk_in = ~clk_in;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic chk_cdb(input string name, input logic cv, input logic [1:0] src,
                           input logic [W-1:0] id, input logic [31:0] val);
        chk({name, "_valid"}, cdb_valid, cv);
        chk({name, "_src"},   cdb_src,   src);
        chk({name, "_id"},    cdb_rob_id, id);
        chk({name, "_value"}, cdb_value, val);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0]   src;
        logic [W-1:0] id;
        logic [31:0]  val;
    } bc_t;

    bc_t exp_q[$];
    bc_t sb_e;
    logic arb_edge = 1'b0;

    function automatic bc_t mkbc(input logic [1:0] s, input logic [W-1:0] id, input logic [31:0] v);
        bc_t b;
        b.src = s;
        b.id  = id;
        b.val = v;
        return b;
    endfunction

    // A broadcast is fresh only after an edge where the arbiter could grant.
    always @(posedge clk_in) arb_edge <= rdy_in && !clear && !rst_in;

    always @(negedge clk_in) begin
        if (arb_edge && cdb_valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: got src %0d id 0x%0h value 0x%0h, required no broadcast",
                         cdb_src, cdb_rob_id, cdb_value);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_bcast", {cdb_src, cdb_rob_id, cdb_value}, sb_e);
                $display("bcast src %0d id 0x%0h value 0x%0h", cdb_src, cdb_rob_id, cdb_value);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic         rdy;
        logic         clr;
        logic [2:0]   vld;
        logic [3*W-1:0] ids;
        logic [95:0]  vals;
        logic [2:0]   exp_ready;
        logic         exp_cv;
        logic [1:0]   exp_src;
        logic [W-1:0] exp_id;
        logic [31:0]  exp_val;
    } vec_t;

    function automatic vec_t mkv(input logic [2:0] vld, input logic [3*W-1:0] ids,
                                 input logic [95:0] vals, input logic [2:0] er,
                                 input logic ecv, input logic [1:0] es,
                                 input logic [W-1:0] eid, input logic [31:0] ev);
        vec_t v;
        v.rdy = 1'b1; v.clr = 1'b0; v.vld = vld; v.ids = ids; v.vals = vals;
        v.exp_ready = er; v.exp_cv = ecv; v.exp_src = es; v.exp_id = eid; v.exp_val = ev;
        return v;
    endfunction

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single ALU push, then a branch push to move rr back to 0.
        vecs[0] = mkv(3'b001, {4'h0, 4'h0, 4'h3}, {32'h0, 32'h0, 32'h11}, 3'b111, 1'b0, 2'd0, 4'h0, 32'h0);
        vecs[1] = mkv(3'b000, '0, '0, 3'b111, 1'b1, 2'd0, 4'h3, 32'h11);
        vecs[2] = mkv(3'b000, '0, '0, 3'b111, 1'b0, 2'd0, 4'h3, 32'h11);
        vecs[3] = mkv(3'b100, {4'h4, 4'h0, 4'h0}, {32'h44, 32'h0, 32'h0}, 3'b111, 1'b0, 2'd0, 4'h3, 32'h11);
        vecs[4] = mkv(3'b000, '0, '0, 3'b111, 1'b1, 2'd2, 4'h4, 32'h44);
        // All three push together with rr = 0.
        vecs[5] = mkv(3'b111, {4'h3, 4'h2, 4'h1}, {32'hC3, 32'hB2, 32'hA1}, 3'b111, 1'b0, 2'd2, 4'h4, 32'h44);
        vecs[6] = mkv(3'b000, '0, '0, 3'b111, 1'b1, 2'd0, 4'h1, 32'hA1);
        vecs[7] = mkv(3'b000, '0, '0, 3'b111, 1'b1, 2'd1, 4'h2, 32'hB2);
        vecs[8] = mkv(3'b000, '0, '0, 3'b111, 1'b1, 2'd2, 4'h3, 32'hC3);
        vecs[9] = mkv(3'b000, '0, '0, 3'b111, 1'b0, 2'd2, 4'h3, 32'hC3);

        // ---------------- reset ----------------
        rdy_in = 1'b1; clear = 1'b0;
        req_valid = 3'b111; req_rob_id = {4'hF, 4'hF, 4'hF}; req_value = '1;
        #1 rst_in = 1'b1;
        #2;
        chk("rst_ready", req_ready, 3'b000);
        chk_cdb("rst", 1'b0, 2'd0, 4'h0, 32'h0);
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        chk_cdb("rst_held", 1'b0, 2'd0, 4'h0, 32'h0);
        req_valid = 3'b000;
        #1 rst_in = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < 10; i++) begin
            rdy_in     = vecs[i].rdy;
            clear      = vecs[i].clr;
            req_valid  = vecs[i].vld;
            req_rob_id = vecs[i].ids;
            req_value  = vecs[i].vals;
            if (vecs[i].exp_cv && vecs[i].rdy && !vecs[i].clr)
                exp_q.push_back(mkbc(vecs[i].exp_src, vecs[i].exp_id, vecs[i].exp_val));
            #1;
            chk($sformatf("vec%0d_ready", i), req_ready, vecs[i].exp_ready);
            step();
            chk_cdb($sformatf("vec%0d", i), vecs[i].exp_cv, vecs[i].exp_src,
                    vecs[i].exp_id, vecs[i].exp_val);
        end
        req_valid = 3'b000;

        // ---------------- back-pressure on the LSB FIFO (rr = 0) ----------------
        exp_q.push_back(mkbc(2'd0, 4'hA, 32'h100));
        exp_q.push_back(mkbc(2'd1, 4'h5, 32'h105));
        exp_q.push_back(mkbc(2'd2, 4'hB, 32'h10B));
        exp_q.push_back(mkbc(2'd1, 4'h6, 32'h106));
        exp_q.push_back(mkbc(2'd1, 4'h7, 32'h107));
        req_valid  = 3'b111;
        req_rob_id = {4'hB, 4'h5, 4'hA};
        req_value  = {32'h10B, 32'h105, 32'h100};
        #1 chk("bp_ready0", req_ready, 3'b111);
        step();
        req_valid  = 3'b010;
        req_rob_id = {4'h0, 4'h6, 4'h0};
        req_value  = {32'h0, 32'h106, 32'h0};
        #1 chk("bp_ready1", req_ready, 3'b111);
        step();
        req_rob_id = {4'h0, 4'h7, 4'h0};
        req_value  = {32'h0, 32'h107, 32'h0};
        #1 chk("bp_full_ready", req_ready, 3'b101);
        chk_cdb("bp_alu", 1'b1, 2'd0, 4'hA, 32'h100);
        step();
        // LSB popped 5 on that edge but 7 was refused because it was full.
        chk("bp_ready_after_pop", req_ready, 3'b111);
        chk_cdb("bp_lsb5", 1'b1, 2'd1, 4'h5, 32'h105);
        step();
        req_valid = 3'b000;
        #1 chk("bp_full_again", req_ready, 3'b101);
        step();
        step();
        step();
        chk("bp_idle_valid", cdb_valid, 1'b0);

        // ---------------- stall with a live broadcast (rr = 2) ----------------
        exp_q.push_back(mkbc(2'd0, 4'h9, 32'h99));
        req_valid = 3'b001; req_rob_id = {4'h0, 4'h0, 4'h9}; req_value = {32'h0, 32'h0, 32'h99};
        step();
        exp_q.push_back(mkbc(2'd2, 4'hD, 32'hDD));
        req_valid = 3'b100; req_rob_id = {4'hD, 4'h0, 4'h0}; req_value = {32'hDD, 32'h0, 32'h0};
        step();
        chk_cdb("stall_start", 1'b1, 2'd0, 4'h9, 32'h99);
        rdy_in = 1'b0;
        req_valid = 3'b010; req_rob_id = {4'h0, 4'hC, 4'h0}; req_value = {32'h0, 32'hCC, 32'h0};
        #1 chk("stall_ready", req_ready, 3'b000);
        for (int k = 0; k < 5; k++) begin
            step();
            chk_cdb($sformatf("stall%0d", k), 1'b1, 2'd0, 4'h9, 32'h99);
        end
        rdy_in = 1'b1; req_valid = 3'b000;
        step();
        chk_cdb("stall_resume", 1'b1, 2'd2, 4'hD, 32'hDD);
        step();
        chk("stall_done_valid", cdb_valid, 1'b0);

        // ---------------- flush with two entries buffered (rr = 0) ----------------
        exp_q.push_back(mkbc(2'd0, 4'h1, 32'h201));
        req_valid = 3'b011; req_rob_id = {4'h0, 4'h2, 4'h1}; req_value = {32'h0, 32'h202, 32'h201};
        step();
        req_valid = 3'b001; req_rob_id = {4'h0, 4'h0, 4'h4}; req_value = {32'h0, 32'h0, 32'h204};
        step();
        chk_cdb("clr_pre", 1'b1, 2'd0, 4'h1, 32'h201);
        clear = 1'b1;
        req_valid = 3'b100; req_rob_id = {4'h3, 4'h0, 4'h0}; req_value = {32'h203, 32'h0, 32'h0};
        #1 chk("clr_ready", req_ready, 3'b000);
        step();
        chk("clr_valid", cdb_valid, 1'b0);
        clear = 1'b0; req_valid = 3'b000;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("clr_empty_ready%0d", k), req_ready, 3'b111);
            step();
            chk($sformatf("clr_quiet%0d", k), cdb_valid, 1'b0);
        end

        // ---------------- reset between edges (rr = 1) ----------------
        exp_q.push_back(mkbc(2'd1, 4'h7, 32'h307));
        req_valid = 3'b111; req_rob_id = {4'h8, 4'h7, 4'h6}; req_value = {32'h308, 32'h307, 32'h306};
        step();
        req_valid = 3'b000;
        step();
        chk_cdb("mrst_pre", 1'b1, 2'd1, 4'h7, 32'h307);
        @(negedge clk_in);
        #1 rst_in = 1'b1;
        #1;
        chk_cdb("mrst_async", 1'b0, 2'd0, 4'h0, 32'h0);
        chk("mrst_ready", req_ready, 3'b000);
        step();
        @(negedge clk_in);
        rst_in = 1'b0;
        step();
        chk("mrst_discard0", cdb_valid, 1'b0);
        step();
        chk("mrst_discard1", cdb_valid, 1'b0);
        exp_q.push_back(mkbc(2'd1, 4'hE, 32'h3EE));
        req_valid = 3'b010; req_rob_id = {4'h0, 4'hE, 4'h0}; req_value = {32'h0, 32'h3EE, 32'h0};
        step();
        req_valid = 3'b000;
        chk("mrst_push_latency", cdb_valid, 1'b0);
        step();
        chk_cdb("mrst_post", 1'b1, 2'd1, 4'hE, 32'h3EE);
        step();
        chk("mrst_post_done", cdb_valid, 1'b0);

        @(negedge clk_in);
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
